// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the CPU and a DMA/boot-loader
// requester. Registered grants, burst limit against starvation, and a mandatory
// idle cycle between owners.
// Optional macro ARB_ROUND_ROBIN_EN: the IDLE tie-break favours the requester that
// did not own the bus last. When it is undefined, the CPU has fixed priority.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_write,
    output logic              cpu_gnt,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_write,
    output logic              dma_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [DATA_W-1:0] dma_rdata
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        StIdle,
        StOwnCpu,
        StOwnDma
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] burst_cnt;
    logic             at_limit;
    logic             cnt_sat;
    logic             pick_cpu;

    // A saturated count is still at the limit, so a long solo owner yields as soon
    // as the other requester shows up.
    assign at_limit = (burst_cnt >= CNT_LIMIT);
    assign cnt_sat  = (burst_cnt == CNT_SAT);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_dma;  // 1: DMA was the most recent owner

    // Tie-break towards whoever did not own the bus last
    assign pick_cpu = cpu_req && (!dma_req || last_dma);
`else
    // Fixed CPU priority
    assign pick_cpu = cpu_req;
`endif

    // Arbitration FSM with registered grants and burst counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            cpu_gnt   <= 1'b0;
            dma_gnt   <= 1'b0;
            burst_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_dma  <= 1'b1;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    burst_cnt <= '0;
                    if (pick_cpu) begin
                        state   <= StOwnCpu;
                        cpu_gnt <= 1'b1;
                    end else if (dma_req) begin
                        state   <= StOwnDma;
                        dma_gnt <= 1'b1;
                    end
                end
                StOwnCpu: begin
                    if (!cpu_req || (at_limit && dma_req)) begin
                        state     <= StIdle;
                        cpu_gnt   <= 1'b0;
                        burst_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_dma  <= 1'b0;
`endif
                    end else if (!cnt_sat) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                end
                StOwnDma: begin
                    if (!dma_req || (at_limit && cpu_req)) begin
                        state     <= StIdle;
                        dma_gnt   <= 1'b0;
                        burst_cnt <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_dma  <= 1'b1;
`endif
                    end else if (!cnt_sat) begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= StIdle;
                    cpu_gnt   <= 1'b0;
                    dma_gnt   <= 1'b0;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

    // Route the owner's request to memory; nothing is driven without an owner and a
    // write strobe never escapes during reset.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_write = cpu_write;
        end else if (dma_gnt) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_write = dma_write;
        end
        if (reset) begin
            mem_write = 1'b0;
        end
    end

    assign cpu_rdata = mem_rdata;
    assign dma_rdata = mem_rdata;

endmodule
